// File: rtl/riscv_pkg.sv
// Shared RV32 constants: word width, NOP encoding, instruction field layout
// and the fetch FSM state type.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  localparam int OP_W   = 7;
  localparam int OP_LSB = 0;
  localparam int F3_W   = 3;
  localparam int F3_LSB = 12;
  localparam int F7_W   = 7;
  localparam int F7_LSB = 25;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_buf.sv
// Small FIFO of {PC, instruction} pairs between the memory response and decode.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_buf
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [XLEN-1:0]         push_pc,
  input  logic [XLEN-1:0]         push_instr,
  input  logic                    pop,
  input  logic                    flush,
  output logic [XLEN-1:0]         head_pc,
  output logic [XLEN-1:0]         head_instr,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PW = $clog2(DEPTH);

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty      = (count == '0);
  assign full       = (count == (PW + 1)'(DEPTH));
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW + 1)'(do_push) - (PW + 1)'(do_pop);
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory request, a small instruction buffer
// toward decode, and redirect handling that discards in-flight wrong-path words.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] Instr,
  output logic [OP_W-1:0] Op,
  output logic [F3_W-1:0] funct3,
  output logic [F7_W-1:0] funct7,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e    state;
  logic [XLEN-1:0] fpc;
  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] head_instr;
  logic            accept;
  logic            consume;
  logic            redirect;
  logic            push;
  logic            room;
  logic            empty;
  logic            full;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_n;

  assign accept      = imem_req_valid && imem_req_ready;
  assign instr_valid = !empty;
  assign consume     = instr_valid && instr_ready;
  assign redirect    = consume && PCSrc;
  assign push        = (state == S_WAIT) && imem_rsp_valid && !redirect && !full;

  // Occupancy after this edge decides whether a request may be raised next cycle.
  assign count_n = redirect ? '0 : count + CW'(push) - CW'(consume);
  assign room    = count_n < CW'(BUF_DEPTH);

  assign imem_req_addr = fpc;

  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_pc    (fpc - 32'd4),
    .push_instr (imem_rsp_data),
    .pop        (consume),
    .flush      (redirect),
    .head_pc    (head_pc),
    .head_instr (head_instr),
    .empty      (empty),
    .full       (full),
    .count      (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_FETCH;
      fpc            <= RESET_PC;
      imem_req_valid <= 1'b0;
    end else begin
      if (redirect)    fpc <= PCTarget & 32'hFFFF_FFFC;
      else if (accept) fpc <= fpc + 32'd4;

      case (state)
        S_FETCH: begin
          // An accept in the redirect cycle fetched the wrong path; drain it.
          if (accept) begin
            state          <= redirect ? S_DRAIN : S_WAIT;
            imem_req_valid <= 1'b0;
          end else begin
            imem_req_valid <= room;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            state          <= S_FETCH;
            imem_req_valid <= room;
          end else if (redirect) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (imem_rsp_valid) begin
            state          <= S_FETCH;
            imem_req_valid <= room;
          end
        end
        default: begin
          state          <= S_FETCH;
          imem_req_valid <= 1'b0;
        end
      endcase
    end
  end

  assign Instr   = empty ? NOP : head_instr;
  assign PC      = empty ? '0 : head_pc;
  assign PCPlus4 = PC + 32'd4;
  assign Op      = Instr[OP_LSB +: OP_W];
  assign funct3  = Instr[F3_LSB +: F3_W];
  assign funct7  = Instr[F7_LSB +: F7_W];
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: program-order and scoreboard model of the decode stream
// fed by a tagged memory model, with directed reset/stall/redirect scenarios.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int          DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] Instr;
  logic [6:0]  Op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        PCSrc = 1'b0;
  logic [31:0] PCTarget = '0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .Instr(Instr), .Op(Op), .funct3(funct3), .funct7(funct7),
    .PC(PC), .PCPlus4(PCPlus4), .PCSrc(PCSrc), .PCTarget(PCTarget)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  entry_t      model_buf[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          epoch = 0;
  int          acc_ep = 0;
  int          acc_seq = 0;
  int          consumed = 0;
  logic [31:0] acc_addr = '0;
  logic [31:0] exp_fetch = RST_PC;
  logic [31:0] exp_flow = RST_PC;
  logic [31:0] hold_addr = '0;
  bit          outstanding = 0;
  bit          hold_pend = 0;
  bit          rand_data = 0;
  int          mem_lat = 1;
  int          mem_seen = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event did not occur within its cycle budget", name);
  endtask

  // Monitor/model: observes what will happen at the next rising edge.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      model_buf.delete();
      epoch++;
      exp_fetch   = RST_PC;
      exp_flow    = RST_PC;
      outstanding = 0;
      hold_pend   = 0;
    end else begin : mon
      entry_t e;
      logic   acc;
      logic   cons;
      logic   redir;
      acc   = imem_req_valid && imem_req_ready;
      cons  = instr_valid && instr_ready;
      redir = cons && PCSrc;

      if (hold_pend) begin
        chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
        chk("req_hold_addr", imem_req_addr, hold_addr);
      end
      if (!instr_valid) chk("empty_nop", Instr, NOP);

      if (cons) begin
        consumed++;
        chk("flow_pc", PC, exp_flow);
        exp_flow = redir ? (PCTarget & 32'hFFFF_FFFC) : exp_flow + 32'd4;
        if (model_buf.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_instr: got PC %h, expected no instruction", PC);
        end else begin
          e = model_buf.pop_front();
          chk("sb_pc", PC, e.pc);
          chk("sb_instr", Instr, e.data);
          chk("pcplus4", PCPlus4, e.pc + 32'd4);
          chk("fields", {15'd0, Op, funct3, funct7},
              {15'd0, e.data[6:0], e.data[14:12], e.data[31:25]});
        end
      end

      if (acc) begin
        if (outstanding) begin
          vectors++;
          miscompares++;
          $display("FAIL second_outstanding: got accept at %h, expected none", imem_req_addr);
        end
        chk("fetch_addr", imem_req_addr, exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
      end

      // A response is kept only if no redirect/reset happened since its request.
      if (imem_rsp_valid) begin
        if (outstanding && acc_ep == epoch && !redir)
          model_buf.push_back('{pc: acc_addr, data: imem_rsp_data});
        outstanding = 0;
      end

      if (acc) begin
        acc_addr    = imem_req_addr;
        acc_ep      = epoch;
        acc_seq++;
        outstanding = 1;
      end

      if (redir) begin
        model_buf.delete();
        epoch++;
        exp_fetch = PCTarget & 32'hFFFF_FFFC;
      end

      hold_pend = imem_req_valid && !imem_req_ready && !redir;
      hold_addr = imem_req_addr;
    end
  end

  // Memory: answers each accepted request mem_lat cycles later; ignores rst.
  always @(posedge clk) begin
    #1;
    if (acc_seq != mem_seen) begin
      mem_seen = acc_seq;
      mem_cnt  = mem_lat;
      mem_addr = acc_addr;
    end
    imem_rsp_valid = 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = rand_data ? $urandom : mem_addr;
      end
    end
  end

  initial begin
    int  c0;
    int  c1;
    int  s0;
    bit  done;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", Instr, NOP);
    chk("rst_pc", PC, 32'd0);
    rst = 1'b0;
    #1;
    chk("req_valid_before_edge", 32'(imem_req_valid), 32'd0);
    @(posedge clk); #1;
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, RST_PC);

    // Streaming with single-cycle memory: wrap through 0, one instr per 2 cycles
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < 26; i++) begin
      @(posedge clk); #1;
      if (i == 5)  c0 = consumed;
      if (i == 25) c1 = consumed;
    end
    chk("throughput", 32'(c1 - c0), 32'd10);

    // Decode stall: buffer fills to DEPTH, fetching stops, then drains in order
    instr_ready = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_instr_valid", 32'(instr_valid), 32'd1);
    chk("stall_buffered", 32'(model_buf.size()), 32'(DEPTH));
    instr_ready = 1'b1;
    repeat (16) begin @(posedge clk); #1; end

    // Reset while a request is outstanding; its response arrives afterwards
    s0 = acc_seq;
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(posedge clk); #1;
      if (acc_seq != s0) done = 1;
    end
    if (!done) fail_now("wait_for_accept");
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("midrst_instr_valid", 32'(instr_valid), 32'd0);
    chk("midrst_pc", PC, 32'd0);
    @(posedge clk); #1;
    chk("late_rsp_ignored", 32'(instr_valid), 32'd0);
    chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("post_rst_req_addr", imem_req_addr, RST_PC);

    // Redirect at head PC 8 while the request to 0xC is outstanding
    mem_lat = 2;
    done = 0;
    for (int i = 0; i < 80 && !done; i++) begin
      @(posedge clk); #1;
      if (instr_valid && PC == 32'h8 && outstanding && acc_addr == 32'hC) begin
        PCSrc       = 1'b1;
        PCTarget    = 32'h100;
        instr_ready = 1'b1;
        done        = 1;
      end else begin
        PCSrc       = 1'b0;
        instr_ready = !(instr_valid && PC == 32'h8);
      end
    end
    if (!done) fail_now("reach_pc8_with_0xC_outstanding");
    @(posedge clk); #1;
    PCSrc = 1'b0;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (instr_valid) begin
        chk("redirect_pc", PC, 32'h100);
        chk("redirect_instr", Instr, 32'h100);
        done = 1;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!done) fail_now("redirect_target_fetch");

    // Randomized traffic
    rand_data = 1;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      imem_req_ready = ($urandom % 4) != 0;
      instr_ready    = ($urandom % 3) != 0;
      PCSrc          = ($urandom % 8) == 0;
      PCTarget       = $urandom;
      mem_lat        = $urandom_range(1, 3);
    end
    PCSrc = 1'b0;
    instr_ready = 1'b1;
    imem_req_ready = 1'b1;
    repeat (20) begin @(posedge clk); #1; end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
